// File: rtl/fb_pkg.sv
// Shared definitions for the feedback-bus framing path: header layout,
// default magic, checker state encoding and the buffered word type.
package fb_pkg;

  localparam int unsigned FB_MAGIC_HI = 31;
  localparam int unsigned FB_MAGIC_LO = 24;
  localparam int unsigned FB_TYPE_HI  = 23;
  localparam int unsigned FB_TYPE_LO  = 16;
  localparam int unsigned FB_LEN_HI   = 15;
  localparam int unsigned FB_LEN_LO   = 0;

  localparam logic [7:0] FB_MAGIC = 8'hFB;

  typedef enum logic [1:0] {
    HDR,
    BODY,
    DROP
  } fb_chk_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } fb_word_t;

endpackage

// File: rtl/fb_skid_buf.sv
// Two-entry ready/valid register cut carrying fb_word_t. The output word is
// a register (one-cycle latency when empty); a second register absorbs the
// word in flight when downstream stalls. not_full is registered so upstream
// ready never depends combinationally on out_ready.
module fb_skid_buf
  import fb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  fb_word_t in_word,
  input  logic     in_valid,
  output logic     not_full,
  output fb_word_t out_word,
  output logic     out_valid,
  input  logic     out_ready
);

  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       push;
  logic       pop;
  fb_word_t   skid;

  // Occupancy bookkeeping for the two entries.
  always_comb begin
    push      = in_valid & not_full;
    pop       = out_valid & out_ready;
    count_nxt = count + {1'b0, push} - {1'b0, pop};
  end

  // Entry storage; out_word only changes when empty or on a pop, so it holds
  // stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      not_full  <= 1'b1;
      out_valid <= 1'b0;
      out_word  <= '0;
      skid      <= '0;
    end else begin
      count     <= count_nxt;
      not_full  <= (count_nxt != 2'd2);
      out_valid <= (count_nxt != 2'd0);
      if (count == 2'd2) begin
        if (pop) out_word <= skid;
      end else if (push) begin
        if (count == 2'd0 || pop) out_word <= in_word;
        else                      skid     <= in_word;
      end
    end
  end

endmodule

// File: rtl/fb_frame_check.sv
// Framing checker: validates packet headers, forwards good packets with a
// regenerated last, truncates runts, cuts overlong packets at the declared
// length, drops bad headers, and keeps saturating per-class counters.
module fb_frame_check
  import fb_pkg::*;
#(
  parameter logic [7:0]  MAGIC   = FB_MAGIC,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      t_data,
  input  logic             t_valid,
  input  logic             t_last,
  output logic             t_ready,
  output logic [31:0]      i_data,
  output logic             i_valid,
  output logic             i_last,
  input  logic             i_ready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] runt_cnt,
  output logic [CNT_W-1:0] long_cnt,
  output logic [CNT_W-1:0] badhdr_cnt
);

  fb_chk_state_t state;
  logic [15:0]   rem;
  logic [15:0]   hdr_len;
  logic          hdr_good;
  logic          beat;
  logic          fwd;
  logic          fwd_last;
  logic          skid_not_full;
  fb_word_t      fwd_word;
  fb_word_t      out_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // rst gating keeps t_ready low for the whole reset interval, while the
  // registered not_full (reset to 1) lets it rise as soon as rst drops.
  assign t_ready = ~rst & ((state == DROP) | skid_not_full);
  assign beat    = t_valid & t_ready;

  // Header decode and forwarding decision for the current input word.
  always_comb begin
    hdr_len  = t_data[FB_LEN_HI:FB_LEN_LO];
    hdr_good = (t_data[FB_MAGIC_HI:FB_MAGIC_LO] == MAGIC) &&
               (32'(hdr_len) <= MAX_LEN);
    fwd      = 1'b0;
    fwd_last = 1'b0;
    case (state)
      HDR: begin
        fwd      = beat & hdr_good;
        fwd_last = (hdr_len == 16'd0) | t_last;
      end
      BODY: begin
        fwd      = beat;
        fwd_last = (rem == 16'd1) | t_last;
      end
      default: ;
    endcase
    fwd_word = '{data: t_data, last: fwd_last};
  end

  // Framing state machine, remaining-length tracker and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR;
      rem        <= '0;
      pkt_cnt    <= '0;
      runt_cnt   <= '0;
      long_cnt   <= '0;
      badhdr_cnt <= '0;
    end else if (beat) begin
      case (state)
        HDR: begin
          if (!hdr_good) begin
            badhdr_cnt <= sat_inc(badhdr_cnt);
            state      <= t_last ? HDR : DROP;
          end else if (hdr_len == 16'd0) begin
            if (t_last) begin
              pkt_cnt <= sat_inc(pkt_cnt);
            end else begin
              long_cnt <= sat_inc(long_cnt);
              state    <= DROP;
            end
          end else if (t_last) begin
            runt_cnt <= sat_inc(runt_cnt);
          end else begin
            rem   <= hdr_len;
            state <= BODY;
          end
        end
        BODY: begin
          rem <= rem - 16'd1;
          if (rem == 16'd1) begin
            if (t_last) begin
              pkt_cnt <= sat_inc(pkt_cnt);
              state   <= HDR;
            end else begin
              long_cnt <= sat_inc(long_cnt);
              state    <= DROP;
            end
          end else if (t_last) begin
            runt_cnt <= sat_inc(runt_cnt);
            state    <= HDR;
          end
        end
        DROP: begin
          if (t_last) state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

  fb_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_word  (fwd_word),
    .in_valid (fwd),
    .not_full (skid_not_full),
    .out_word (out_word),
    .out_valid(i_valid),
    .out_ready(i_ready)
  );

  assign i_data = out_word.data;
  assign i_last = out_word.last;

endmodule

// File: doc/fb_frame_check.md
# fb_frame_check

Framing checker on the feedback bus, directly downstream of the FB/EQ join stage. Consumes the joined word stream, validates each packet's header (magic, length bound), and forwards well-formed packets unchanged. Runt packets are truncated at the early last and overlong packets are cut at the declared length. Bad-header packets are discarded whole. Per-class counters are exposed for status registers. Output is registered through a 2-entry skid buffer, so downstream backpressure never combinationally reaches the join stage.

## Interface
Parameters:
- MAGIC, 8'hFB: required value of header bits [31:24].
- MAX_LEN, 1024: largest legal payload length L, in words after the header.
- CNT_W, 16: width of each saturating status counter.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- t_data  in  32  input word (from join stage i_data).
- t_valid  in  1  input valid.
- t_last  in  1  input last word of packet.
- t_ready  out  1  input accept.
- i_data  out  32  output word.
- i_valid  out  1  output valid.
- i_last  out  1  output last (regenerated, not copied).
- i_ready  in  1  output accept.
- pkt_cnt  out  CNT_W  good packets forwarded.
- runt_cnt  out  CNT_W  packets truncated by early t_last.
- long_cnt  out  CNT_W  packets cut at L with data remaining.
- badhdr_cnt  out  CNT_W  packets dropped for magic or length.

## Operation
- Header word: [31:24] magic, [23:16] type (opaque), [15:0] L. The header is forwarded as the first output word.
- Input beat = t_valid & t_ready. Output beat = i_valid & i_ready.
- States are HDR, BODY and DROP. Reset state is HDR.
- HDR, on input beat, bad header (magic≠MAGIC or L>MAX_LEN):
  - Word is not forwarded.
  - badhdr_cnt+1.
  - Next state is HDR if t_last, else DROP.
- HDR, on input beat, good header, L=0:
  - Forward with i_last=1.
  - If t_last: pkt_cnt+1, next state HDR. Otherwise: long_cnt+1, next state DROP.
- HDR, on input beat, good header, L>0:
  - If t_last: forward with i_last=1, runt_cnt+1, stay in HDR.
  - Otherwise: forward with i_last=0, rem←L, next state BODY.
- BODY, on input beat: forward the word and set rem←rem−1.
  - If rem=1: i_last=1. If t_last: pkt_cnt+1, next state HDR. Otherwise: long_cnt+1, next state DROP.
  - Else if t_last: i_last=1, runt_cnt+1, next state HDR.
- DROP: t_ready=1 unconditionally and nothing is forwarded. On an input beat with t_last, next state is HDR.
- t_ready = (state==DROP) | skid_not_full. skid_not_full is a registered signal.
- Counters saturate at all-ones and never wrap.
- rem is 16 bits.

## Timing
- Reset values: t_ready=0 and i_valid=0 while rst is high. i_data=0, i_last=0, all counters 0, rem=0, skid buffer empty. In the first cycle after rst falls, t_ready=1.
- Latency: a word accepted in cycle N is presented on i_* in cycle N+1 when the skid buffer is empty.
- Throughput: 1 word/cycle with i_ready held high.
- i_ready low: the buffer absorbs at most 2 words. t_ready drops in the cycle after the second word is stored, and the 2-entry buffer holds that word.
- i_data and i_last hold stable while i_valid=1 and i_ready=0.
- A counter increment occurs the cycle after the deciding input beat. It is independent of output drain.
- Simultaneous output beat and input beat with the buffer full: the occupancy test uses registered state, so t_ready reasserts one cycle later. This is a throughput bubble only; no word is lost.
- Reset mid-packet: the partial packet is abandoned, buffered words are discarded, and the next accepted word is treated as a header.
- DROP state: the skid buffer keeps draining independently.

## Structure
- Shared package fb_pkg holds:
  - header field bit positions: FB_MAGIC_HI/LO, FB_TYPE_HI/LO, FB_LEN_HI/LO;
  - the default FB_MAGIC;
  - the state enum fb_chk_state_t {HDR, BODY, DROP};
  - a fb_word_t struct {data[31:0], last}.
- Sub-module fb_skid_buf: a 2-entry ready/valid buffer carrying fb_word_t. It exposes a registered not_full flag. It is reused wherever the bus needs a register cut.

## Test plan
- Good packet: header 0xFB00_0003 plus 3 payload words, last on word 4, i_ready=1 → 4 words out at 1/cycle, 1-cycle latency, i_last on word 4 only, pkt_cnt=1.
- Runt: header L=5, t_last on the 2nd payload word → 3 words out, i_last on 3rd, runt_cnt=1, next header accepted normally.
- Overlong: header L=2, 6 payload words → header plus 2 payload words out with i_last on the 3rd output word. The 4 extra words are consumed with no output, long_cnt=1.
- Bad header:
  - magic 0xFA, 10-word packet → no output, badhdr_cnt=1, t_ready stays 1 throughout.
  - L=1025 with MAX_LEN=1024 → same response.
- Backpressure: i_ready toggling with a random 50% pattern across 100 back-to-back good packets → output identical to input, no loss or duplication, pkt_cnt=100.
- Reset mid-BODY with 2 words buffered → i_valid=0 the cycle after rst rises. After release, a fresh L=0 single-word packet passes with i_last=1.
